// File: rtl/ram_access_arbiter.sv
// Shares a byte-wide RAM between the pipeline MEM stage and an aux master, splitting word
// accesses into big-endian byte beats. Define ARB_ROUND_ROBIN_EN for round-robin arbitration.
module ram_access_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              R,
  input  logic              mem_e,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_di,
  output logic [31:0]       mem_do,
  output logic              mem_stall,
  input  logic              aux_req,
  input  logic              aux_rw,
  input  logic              aux_size,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [31:0]       aux_di,
  output logic [31:0]       aux_do,
  output logic              aux_ack,
  output logic              ram_e,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_di,
  input  logic [7:0]        ram_do
);

  // state | meaning
  // IDLE  | no transfer; grant a pending request and latch its fields
  // XFER  | one RAM beat per cycle until the last beat
  // DONE  | read data presented; pipe stall released or aux_ack pulsed
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic PIPE = 1'b0;
  localparam logic AUX  = 1'b1;

  state_t              state, state_nx;
  logic [1:0]          beat;
  logic                owner;
  logic                rw_q;
  logic                size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         di_q;
  logic [31:0]         rd_q;
  logic [31:0]         rd_nx;
  logic [7:0]          wr_byte;
  logic                grant_mem;
  logic                grant_aux;
  logic                last_beat;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;

  always_comb begin
    grant_mem = mem_e;
    grant_aux = aux_req;
    if (mem_e && aux_req) begin
      grant_aux = (last_owner == PIPE);
      grant_mem = (last_owner == AUX);
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      last_owner <= AUX;
    end else if (state == IDLE && (grant_mem || grant_aux)) begin
      last_owner <= grant_aux ? AUX : PIPE;
    end
  end
`else
  always_comb begin
    grant_mem = mem_e;
    grant_aux = aux_req & ~mem_e;
  end
`endif

  assign last_beat = size_q ? (beat == 2'd3) : 1'b1;

  // Beat 0 carries the most significant byte of a word.
  always_comb begin
    wr_byte = di_q[7:0];
    rd_nx   = rd_q;
    if (size_q) begin
      case (beat)
        2'd0: begin wr_byte = di_q[31:24]; rd_nx[31:24] = ram_do; end
        2'd1: begin wr_byte = di_q[23:16]; rd_nx[23:16] = ram_do; end
        2'd2: begin wr_byte = di_q[15:8];  rd_nx[15:8]  = ram_do; end
        default: begin wr_byte = di_q[7:0]; rd_nx[7:0] = ram_do; end
      endcase
    end else begin
      rd_nx = {24'h0, ram_do};
    end
  end

  always_ff @(posedge clk) begin
    if (R) state <= IDLE;
    else   state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    ram_e     = 1'b0;
    ram_rw    = 1'b0;
    ram_addr  = '0;
    ram_di    = 8'h00;
    aux_ack   = 1'b0;
    mem_stall = mem_e;
    case (state)
      IDLE: begin
        if (grant_mem || grant_aux) state_nx = XFER;
      end
      XFER: begin
        ram_e    = 1'b1;
        ram_rw   = rw_q;
        ram_addr = addr_q + ADDR_W'(beat);
        ram_di   = wr_byte;
        if (last_beat) state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        aux_ack  = (owner == AUX);
        if (owner == PIPE) mem_stall = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
    // Reset must silence the RAM immediately, even mid-transfer.
    if (R) begin
      ram_e    = 1'b0;
      ram_rw   = 1'b0;
      ram_addr = '0;
      ram_di   = 8'h00;
      aux_ack  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (R) begin
      beat   <= 2'd0;
      owner  <= PIPE;
      rw_q   <= 1'b0;
      size_q <= 1'b0;
      addr_q <= '0;
      di_q   <= 32'h0;
      rd_q   <= 32'h0;
      mem_do <= 32'h0;
      aux_do <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_mem || grant_aux) begin
            owner  <= grant_aux ? AUX : PIPE;
            rw_q   <= grant_aux ? aux_rw   : mem_rw;
            size_q <= grant_aux ? aux_size : mem_size;
            addr_q <= grant_aux ? aux_addr : mem_addr;
            di_q   <= grant_aux ? aux_di   : mem_di;
            beat   <= 2'd0;
            rd_q   <= 32'h0;
          end
        end
        XFER: begin
          if (!rw_q) rd_q <= rd_nx;
          // Read data lands in the output register as the last beat completes, so it is
          // already valid during DONE; writes leave the last read value in place.
          if (last_beat) begin
            if (!rw_q) begin
              if (owner == AUX) aux_do <= rd_nx;
              else              mem_do <= rd_nx;
            end
          end else begin
            beat <= beat + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
